exu_muldiv: RTL and testbench

Multi-cycle RV32M execute unit, parametrised in data width, running beside the single-cycle integer ALU in the EX stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time over a valid/ready handshake. Multiplies use a fixed-latency registered pipeline; divides use an iterative restoring divider. Results are returned with the destination register tag so the pipeline can stall, forward and write back.

---
 rtl/exu_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_exu_muldiv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv.sv
// RV32M multiply/divide unit: MUL_LAT-cycle multiply, XLEN+1-cycle restoring divide, 1-cycle divide special cases.
// One op in flight; the result is held in DONE until out_ready, and flush returns the unit to IDLE from any state.
module exu_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int DCW = $clog2(XLEN) + 1;
  localparam int MCW = $clog2(MUL_LAT) + 1;
  localparam int CW  = (DCW > MCW) ? DCW : MCW;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      fn_q, fn_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;

  logic              sgn_in, b_zero, ovf;
  logic              sa, sb;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN:0]     shifted, trial;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign rd_o      = rd_q;

  assign sgn_in = ~funct3[0];
  assign b_zero = (op_b == '0);
  assign ovf    = sgn_in && (op_a == MIN_NEG) && (op_b == '1);

  // Sign-extend to 2*XLEN; modular product of the extended operands is the exact signed/unsigned product.
  assign sa    = (fn_q != 2'b11);
  assign sb    = ~fn_q[1];
  assign a_ext = {{XLEN{sa & a_q[XLEN-1]}}, a_q};
  assign b_ext = {{XLEN{sb & b_q[XLEN-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Restoring step: a_q doubles as the dividend/quotient shift register.
  assign shifted = {rem_q, a_q[XLEN-1]};
  assign trial   = shifted - {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fn_d        = fn_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    rd_d        = rd_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            fn_d  = funct3[1:0];
            rd_d  = rd;
            cnt_d = '0;
            if (!funct3[2]) begin
              a_d     = op_a;
              b_d     = op_b;
              state_d = S_MUL;
            end else begin
              a_d     = mag(op_a, sgn_in);
              b_d     = mag(op_b, sgn_in);
              rem_d   = '0;
              negq_d  = sgn_in & (op_a[XLEN-1] ^ op_b[XLEN-1]);
              negr_d  = sgn_in & op_a[XLEN-1];
              state_d = S_DIV;
              // Special cases preload final values and jump straight to the sign/finish step.
              if (b_zero || ovf) begin
                a_d    = b_zero ? '1 : op_a;
                rem_d  = b_zero ? op_a : '0;
                negq_d = 1'b0;
                negr_d = 1'b0;
                cnt_d  = CW'(XLEN);
              end
            end
          end
        end
        S_MUL: begin
          if (cnt_q == CW'(MUL_LAT - 1)) begin
            result_d    = (fn_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DIV: begin
          if (cnt_q == CW'(XLEN)) begin
            if (fn_q[1]) result_d = negr_q ? -rem_q : rem_q;
            else         result_d = negq_q ? -a_q : a_q;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            if (!trial[XLEN]) begin
              rem_d = trial[XLEN-1:0];
              a_d   = {a_q[XLEN-2:0], 1'b1};
            end else begin
              rem_d = shifted[XLEN-1:0];
              a_d   = {a_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fn_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fn_q        <= fn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Randomized and directed checks of exu_muldiv against a plain-arithmetic RV32M model.
module tb_exu_muldiv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_o;
  logic        busy;

  int checks = 0;
  int errors = 0;

  exu_muldiv #(.XLEN(32), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd        (rd),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_o      (rd_o),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issues one op (called at any time; aligns to a falling edge), checks latency/result/tag,
  // holds out_ready low for 'hold' cycles with stray in_valid, then releases.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int hold);
    logic [31:0] exp;
    int n;
    exp = ref_res(f, a, b);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    funct3 = f; op_a = a; op_b = b; rd = r; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, ref_lat(f, a, b));
    chk("result", result, exp);
    chk("rd_o", rd_o, r);
    chk("in_ready_done", in_ready, 1'b0);
    chk("busy_done", busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; funct3 = 3'd0; op_a = $urandom; op_b = $urandom; rd = 5'd31;
      @(negedge clk);
      chk("bp_result", result, exp);
      chk("bp_rd_o", rd_o, r);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_valid", out_valid, 1'b0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd = '0;
    #3;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_rd_o", rd_o, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 0);
    run_op(3'd5, 32'd100, 32'd0, 5'd9, 0);
    run_op(3'd6, 32'd100, 32'd0, 5'd10, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    run_op(3'd4, 32'd1234, 32'd10, 5'd13, 5);
    run_op(3'd0, 32'd3, 32'd9, 5'd14, 0);

    // Flush at divide iteration 10.
    @(negedge clk);
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd = 5'd15; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_div_in_ready", in_ready, 1'b1);
    chk("flush_div_busy", busy, 1'b0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("flush_div_no_valid", seen, 0);

    // Flush coinciding with in_valid in IDLE.
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5; rd = 5'd16; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 1'b0);
    seen = 0;
    repeat (5) begin @(negedge clk); if (out_valid) seen++; end
    chk("flush_idle_no_valid", seen, 0);

    // Flush in DONE wins over out_ready.
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7; rd = 5'd17; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_done_pre", out_valid, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", out_valid, 1'b0);
    chk("flush_done_in_ready", in_ready, 1'b1);

    // Asynchronous reset mid-multiply.
    @(negedge clk);
    funct3 = 3'd3; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd = 5'd18; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("mid_mul_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_result", result, 32'h0);
    chk("arst_rd_o", rd_o, 5'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (out_valid || busy) seen++; end
    chk("post_rst_quiet", seen, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
